// File: rtl/lab01_input_sequencer_if.sv
// rtl/lab01_input_sequencer_if.sv - stimulus/response bundle between board-side logic and the input sequencer
// Optional SELF_CHECK_EN adds the mismatch flag and counter.
interface lab01_input_sequencer_if;
  logic [3:0]  sw;
  logic        btn_step;
  logic        mode;
  logic [3:0]  resp_in;
  logic [3:0]  abcd;
  logic [3:0]  vec_idx;
  logic        busy;
  logic        done;
  logic [63:0] resp_table;
`ifdef SELF_CHECK_EN
  logic        mismatch;
  logic [4:0]  mismatch_cnt;

  modport master (
    output sw, btn_step, mode, resp_in,
    input  abcd, vec_idx, busy, done, resp_table, mismatch, mismatch_cnt
  );
  modport slave (
    input  sw, btn_step, mode, resp_in,
    output abcd, vec_idx, busy, done, resp_table, mismatch, mismatch_cnt
  );
`else
  modport master (
    output sw, btn_step, mode, resp_in,
    input  abcd, vec_idx, busy, done, resp_table
  );
  modport slave (
    input  sw, btn_step, mode, resp_in,
    output abcd, vec_idx, busy, done, resp_table
  );
`endif
endinterface

// File: rtl/lab01_input_sequencer.sv
// rtl/lab01_input_sequencer.sv - manual/sweep stimulus driver for the 4-in/4-out decoder with response capture
// Define SELF_CHECK_EN to add the golden-model comparator (mismatch, mismatch_cnt).
module lab01_input_sequencer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TICK_DIV        = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  lab01_input_sequencer_if.slave  bus_io
);

  localparam int         DB_W      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] TICK_LAST = 8'(TICK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_CAPTURE, S_DONE} state_t;

  logic            sync1_q, sync2_q;
  logic            level_q, level_prev_q;
  logic            step_pulse_q;
  logic [DB_W-1:0] db_cnt_q;

  state_t      state_q, state_d;
  logic [3:0]  abcd_q, abcd_d;
  logic [3:0]  vec_idx_q, vec_idx_d;
  logic [7:0]  tick_q, tick_d;
  logic [63:0] table_q, table_d;
  logic        busy, done;

`ifdef SELF_CHECK_EN
  logic       mismatch_q, mismatch_d;
  logic [4:0] mismatch_cnt_q, mismatch_cnt_d;

  function automatic logic [3:0] golden(input logic [3:0] v);
    logic a, b, c, d;
    {a, b, c, d} = v;
    golden = {a | (b & d) | (b & c),
              b & ~c,
              b | c,
              (a & ~d) | (b & c & d) | (~b & c & ~d) | (~a & ~b & ~c & d)};
  endfunction
`endif

  // Level changes only after DEBOUNCE_CYCLES consecutive disagreeing samples; pulse lags the rise by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      step_pulse_q <= 1'b0;
      db_cnt_q     <= '0;
    end else begin
      sync1_q      <= bus_io.btn_step;
      sync2_q      <= sync1_q;
      level_prev_q <= level_q;
      step_pulse_q <= level_q & ~level_prev_q;
      if (sync2_q == level_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DB_LAST) begin
        level_q  <= sync2_q;
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      abcd_q    <= '0;
      vec_idx_q <= '0;
      tick_q    <= '0;
      table_q   <= '0;
`ifdef SELF_CHECK_EN
      mismatch_q     <= 1'b0;
      mismatch_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      abcd_q    <= abcd_d;
      vec_idx_q <= vec_idx_d;
      tick_q    <= tick_d;
      table_q   <= table_d;
`ifdef SELF_CHECK_EN
      mismatch_q     <= mismatch_d;
      mismatch_cnt_q <= mismatch_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    abcd_d    = abcd_q;
    vec_idx_d = vec_idx_q;
    tick_d    = tick_q;
    table_d   = table_q;
`ifdef SELF_CHECK_EN
    mismatch_d     = mismatch_q;
    mismatch_cnt_d = mismatch_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!bus_io.mode) begin
          abcd_d = bus_io.sw;
        end else if (step_pulse_q) begin
          state_d   = S_DRIVE;
          vec_idx_d = 4'd0;
          abcd_d    = 4'd0;
          tick_d    = 8'd0;
`ifdef SELF_CHECK_EN
          mismatch_d     = 1'b0;
          mismatch_cnt_d = 5'd0;
`endif
        end
      end
      S_DRIVE: begin
        if (!bus_io.mode) begin
          state_d = S_IDLE;
        end else if (tick_q == TICK_LAST) begin
          state_d = S_CAPTURE;
        end else begin
          tick_d = tick_q + 8'd1;
        end
      end
      S_CAPTURE: begin
        // An abort wins over the capture, so the slot under test keeps its previous value.
        if (!bus_io.mode) begin
          state_d = S_IDLE;
        end else begin
          table_d[{vec_idx_q, 2'b00} +: 4] = bus_io.resp_in;
`ifdef SELF_CHECK_EN
          if (golden(abcd_q) != bus_io.resp_in) begin
            mismatch_d = 1'b1;
            if (mismatch_cnt_q != 5'd31) mismatch_cnt_d = mismatch_cnt_q + 5'd1;
          end
`endif
          if (vec_idx_q == 4'hF) begin
            state_d = S_DONE;
          end else begin
            state_d   = S_DRIVE;
            vec_idx_d = vec_idx_q + 4'd1;
            abcd_d    = vec_idx_q + 4'd1;
            tick_d    = 8'd0;
          end
        end
      end
      S_DONE: begin
        if (!bus_io.mode || step_pulse_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_DRIVE, S_CAPTURE: busy = 1'b1;
      S_DONE:             done = 1'b1;
      default: ;
    endcase
  end

  assign bus_io.abcd       = abcd_q;
  assign bus_io.vec_idx    = vec_idx_q;
  assign bus_io.busy       = busy;
  assign bus_io.done       = done;
  assign bus_io.resp_table = table_q;
`ifdef SELF_CHECK_EN
  assign bus_io.mismatch     = mismatch_q;
  assign bus_io.mismatch_cnt = mismatch_cnt_q;
`endif

endmodule

// File: tb/tb_lab01_input_sequencer.sv
// tb/tb_lab01_input_sequencer.sv - directed/randomized bench for lab01_input_sequencer with a decoder and table model
module tb_lab01_input_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic corrupt = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  logic [3:0] ref_tbl [16];
  logic [3:0] prev_sw;
  logic [3:0] new_sw;
  int   abort_idx;
  int   abort_off;

  lab01_input_sequencer_if bus ();

  lab01_input_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .TICK_DIV(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus_io(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] dec(input logic [3:0] v);
    logic a, b, c, d;
    {a, b, c, d} = v;
    dec = {a | (b & d) | (b & c),
           b & ~c,
           b | c,
           (a & ~d) | (b & c & d) | (~b & c & ~d) | (~a & ~b & ~c & d)};
  endfunction

  // Decoder under test, with an optional fault on z for vector 3.
  always_comb bus.resp_in = dec(bus.abcd) ^ ((corrupt && bus.abcd == 4'd3) ? 4'b0001 : 4'b0000);

  function automatic logic [63:0] ref_packed();
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[4*i +: 4] = ref_tbl[i];
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_expect_start();
    bus.btn_step = 1'b1;
    cyc(7);
    check("start_early", 64'(bus.busy), 64'd0);
    cyc(1);
    check("start_busy", {bus.busy, bus.done, bus.vec_idx, bus.abcd}, {1'b1, 1'b0, 4'd0, 4'd0});
  endtask

  task automatic run_sweep();
    logic [3:0] idx;
    for (int k = 1; k <= 144; k++) begin
      if (k == 20) bus.btn_step = 1'b0;
      if (k == 40) bus.btn_step = 1'b1;
      if (k == 60) bus.btn_step = 1'b0;
      @(negedge clk);
      idx = (k / 9 > 15) ? 4'd15 : 4'(k / 9);
      check($sformatf("sweep_k%0d", k), {bus.busy, bus.done, bus.vec_idx, bus.abcd},
            {(k < 144), (k >= 144), idx, idx});
    end
    for (int i = 0; i < 16; i++) ref_tbl[i] = dec(4'(i)) ^ ((corrupt && i == 3) ? 4'b0001 : 4'b0000);
    check("sweep_table", bus.resp_table, ref_packed());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) ref_tbl[i] = 4'd0;
    rst          = 1'b1;
    bus.sw       = 4'b1010;
    bus.mode     = 1'b0;
    bus.btn_step = 1'b0;
    cyc(2);
    check("rst_outs", {bus.abcd, bus.vec_idx, bus.busy, bus.done}, 64'd0);
    check("rst_table", bus.resp_table, 64'd0);

    rst = 1'b0;
    cyc(1);
    check("manual_first", {bus.abcd, bus.busy, bus.done}, {4'b1010, 1'b0, 1'b0});
    prev_sw = 4'b1010;
    repeat (10) begin
      new_sw = 4'($urandom);
      bus.sw = new_sw;
      check("manual_latency", 64'(bus.abcd), 64'(prev_sw));
      cyc(1);
      check("manual_track", {bus.abcd, bus.busy, bus.done}, {new_sw, 1'b0, 1'b0});
      prev_sw = new_sw;
    end

    bus.mode = 1'b1;
    repeat (2) begin
      bus.btn_step = 1'b1;
      cyc(3);
      bus.btn_step = 1'b0;
      cyc(2);
      check("bounce_no_start", 64'(bus.busy), 64'd0);
    end
    press_expect_start();
    run_sweep();

    bus.btn_step = 1'b1;
    cyc(7);
    check("rearm_done_hold", 64'(bus.done), 64'd1);
    cyc(1);
    check("rearm_idle", {bus.busy, bus.done}, 2'b00);
    check("rearm_table_kept", bus.resp_table, ref_packed());
    bus.btn_step = 1'b0;
    cyc(20);
    check("release_no_start", {bus.busy, bus.done, bus.abcd}, {1'b0, 1'b0, 4'hF});

    corrupt = 1'b1;
    press_expect_start();
`ifdef SELF_CHECK_EN
    check("sc_clear_start", {bus.mismatch, bus.mismatch_cnt}, 6'd0);
`endif
    run_sweep();
`ifdef SELF_CHECK_EN
    check("sc_flag", {bus.mismatch, bus.mismatch_cnt}, {1'b1, 5'd1});
`endif
    corrupt = 1'b0;

    bus.btn_step = 1'b1;
    cyc(8);
    check("second_idle", {bus.busy, bus.done}, 2'b00);
`ifdef SELF_CHECK_EN
    check("sc_kept_idle", {bus.mismatch, bus.mismatch_cnt}, {1'b1, 5'd1});
`endif
    bus.btn_step = 1'b0;
    cyc(12);

    abort_idx = $urandom_range(1, 14);
    abort_off = $urandom_range(0, 7);
    press_expect_start();
`ifdef SELF_CHECK_EN
    check("sc_cleared", {bus.mismatch, bus.mismatch_cnt}, 6'd0);
`endif
    bus.btn_step = 1'b0;
    cyc(9 * abort_idx + abort_off);
    check("abort_point", {bus.busy, bus.vec_idx}, {1'b1, 4'(abort_idx)});
    bus.mode = 1'b0;
    new_sw   = 4'($urandom);
    bus.sw   = new_sw;
    cyc(1);
    check("abort_idle", {bus.busy, bus.done}, 2'b00);
    cyc(1);
    check("abort_manual", 64'(bus.abcd), 64'(new_sw));
    for (int i = 0; i < abort_idx; i++) ref_tbl[i] = dec(4'(i));
    check("abort_table", bus.resp_table, ref_packed());

    bus.mode = 1'b1;
    cyc(2);
    press_expect_start();
    bus.btn_step = 1'b0;
    cyc(30);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_outs", {bus.abcd, bus.vec_idx, bus.busy, bus.done}, 64'd0);
    check("async_rst_table", bus.resp_table, 64'd0);
    cyc(2);
    rst = 1'b0;
    cyc(3);
    check("post_rst_idle", {bus.abcd, bus.busy, bus.done}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
